// File: rtl/alu8_seq.sv
// alu8_seq -- 8-bit sequential ALU built on an external 4-bit ALU slice.
// Each command is split into two nibble passes. The low nibble is done in LO and the
// high nibble in HI. The low-nibble carry is registered and fed back in as the HI
// carry-in. Subtract, less-than and equal all run as a + ~b + 1 through the slice.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   in_valid/in_ready        command handshake; in_a, in_b operands; in_op opcode
//   out_valid/out_ready      result handshake
//   out_result, out_zero, out_overflow, out_carry, out_size   registered result and flags
//   alu_a, alu_b, alu_c, alu_cin                              drive to the 4-bit slice
//   alu_result, alu_carry, alu_overflow                       combinational slice return
//
// Configuration
//   ALU8_SEQ_OVLP_EN  when defined, DONE can accept the next command while the
//                     current result is consumed (DONE->LO), giving 1 op / 3 cycles.
module alu8_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   input  logic [2:0] in_op,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_result,
   output logic       out_zero,
   output logic       out_overflow,
   output logic       out_carry,
   output logic       out_size,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_c,
   output logic       alu_cin,
   input  logic [3:0] alu_result,
   input  logic       alu_carry,
   input  logic       alu_overflow
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t     state_q, state_d;
   logic [7:0] a_q, b_q, res_q;
   logic [2:0] op_q;
   logic       carry_q, zero_q, ovf_q, cy_q, size_q;

   logic       accept;
   logic       arith;   // op goes through the slice adder
   logic       inv_b;   // subtract form: a + ~b + 1
   logic [3:0] nib_a, nib_b;
   logic [7:0] full_res;

   assign accept   = in_valid && in_ready;
   assign arith    = (op_q == 3'b000) || (op_q == 3'b001) ||
                     (op_q == 3'b110) || (op_q == 3'b111);
   assign inv_b    = arith && (op_q != 3'b000);
   assign nib_a    = (state_q == LO) ? a_q[3:0] : a_q[7:4];
   assign nib_b    = (state_q == LO) ? b_q[3:0] : b_q[7:4];
   assign full_res = {alu_result, res_q[3:0]};

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = LO;
         LO:   state_d = HI;
         HI:   state_d = DONE;
         DONE: begin
            if (out_ready) begin
`ifdef ALU8_SEQ_OVLP_EN
               state_d = accept ? LO : IDLE;
`else
               state_d = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      in_ready  = (state_q == IDLE);
`ifdef ALU8_SEQ_OVLP_EN
      if ((state_q == DONE) && out_ready) in_ready = 1'b1;
`endif
      out_valid = (state_q == DONE);
      alu_a     = 4'h0;
      alu_b     = 4'h0;
      alu_c     = 3'b000;
      alu_cin   = 1'b0;
      if ((state_q == LO) || (state_q == HI)) begin
         alu_a   = nib_a;
         alu_b   = inv_b ? ~nib_b : nib_b;
         alu_c   = arith ? 3'b000 : op_q;
         // LO injects the +1 of the subtract form; HI chains the low-nibble carry
         alu_cin = (state_q == LO) ? inv_b : (arith && carry_q);
      end
   end

   // datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         op_q    <= 3'b000;
         res_q   <= 8'h00;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cy_q    <= 1'b0;
         size_q  <= 1'b0;
      end else begin
         if (accept) begin
            a_q  <= in_a;
            b_q  <= in_b;
            op_q <= in_op;
         end
         if (state_q == LO) begin
            res_q[3:0] <= alu_result;
            carry_q    <= alu_carry;
         end
         if (state_q == HI) begin
            res_q[7:4] <= alu_result;
            zero_q     <= (full_res == 8'h00);
            cy_q       <= arith && alu_carry;
            ovf_q      <= arith && alu_overflow;
            // signed a<b is the sign of a-b corrected by overflow
            if (op_q == 3'b110)      size_q <= alu_result[3] ^ alu_overflow;
            else if (op_q == 3'b111) size_q <= (full_res == 8'h00);
            else                     size_q <= 1'b0;
         end
      end
   end

   assign out_result   = res_q;
   assign out_zero     = zero_q;
   assign out_overflow = ovf_q;
   assign out_carry    = cy_q;
   assign out_size     = size_q;

endmodule

// File: doc/alu8_seq.md
ALU8_SEQ -- requirements
Module: alu8_seq

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-002 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-003 SHALL have ports: in_valid  input  1 / in_ready  output  1  command handshake.
REQ-004 SHALL have ports: in_a, in_b  input  8 each  signed operands.
REQ-005 SHALL have port: in_op  input  3  000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
REQ-006 SHALL have ports: out_valid  output  1 / out_ready  input  1  result handshake.
REQ-007 SHALL have ports: out_result  output  8; out_zero, out_overflow, out_carry, out_size  output  1 each.
REQ-008 SHALL have ports: alu_a, alu_b  output  4 each; alu_c  output  3; alu_cin  output  1; these drive the external 4-bit ALU slice.
REQ-009 SHALL have ports: alu_result  input  4; alu_carry, alu_overflow  input  1 each; returned by the ALU slice combinationally in the same cycle.

Function
REQ-010 SHALL implement FSM states IDLE, LO, HI, DONE.
REQ-011 in_ready SHALL be 1 only in IDLE, plus the DONE case in REQ-029.
REQ-012 An in_valid&&in_ready cycle SHALL register in_a, in_b and in_op, then move to LO.
REQ-013 LO SHALL drive the low nibbles, HI the high nibbles; alu_a SHALL be the a nibble.
REQ-014 For ops 000/001/110/111, alu_c SHALL be 000 (add).
REQ-015 For op 000, alu_b SHALL be the b nibble.
REQ-016 For ops 001/110/111, alu_b SHALL be the inverted b nibble.
REQ-017 alu_cin in LO SHALL be 0 for op 000 and 1 for ops 001/110/111.
REQ-018 alu_cin in HI SHALL be the alu_carry registered at the end of LO.
REQ-019 For ops 010..101, alu_c SHALL equal in_op, alu_b SHALL be the raw b nibble and alu_cin SHALL be 0.
REQ-020 LO SHALL register alu_result as result[3:0]; HI SHALL register alu_result as result[7:4] plus alu_carry and alu_overflow; both states SHALL then advance.
REQ-021 Latency SHALL be accept at cycle T, out_valid=1 from cycle T+3.
REQ-022 out_zero SHALL be 1 iff result==8'h00, computed locally and never taken from the ALU.
REQ-023 out_carry and out_overflow SHALL be the HI-nibble values for ops 000/001/110/111 and 0 otherwise.
REQ-024 out_size for op 110 SHALL be result[7]^overflow (1 iff a<b signed).
REQ-025 out_size for op 111 SHALL equal out_zero; for all other ops it SHALL be 0.
REQ-026 DONE SHALL hold out_valid=1 and all outputs stable until out_ready=1, then go to IDLE.
REQ-027 in_valid outside an in_ready cycle SHALL be ignored; no command is lost or duplicated.
REQ-028 Outputs alu_* SHALL be 0 in IDLE and DONE.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE from any state, including mid-operation in LO or HI; the in-flight command SHALL be discarded.
REQ-031 After reset: in_ready=1; out_valid=0; out_result=0; all flags 0; alu_*=0; internal carry register 0.
REQ-032 rst SHALL take priority over both handshakes in the same cycle.

Configuration
REQ-029 With macro ALU8_SEQ_OVLP_EN defined, in_ready SHALL also be 1 in DONE when out_ready=1; a simultaneous accept SHALL go DONE->LO, sustaining 1 op per 3 cycles.
REQ-033 Without ALU8_SEQ_OVLP_EN, DONE SHALL always return to IDLE and throughput SHALL be 1 op per 4 cycles; all other behaviour SHALL be identical.

Verification
REQ-034 Reset then add 0x7F+0x01, out_ready=1: result=0x80, overflow=1, carry=0, zero=0, out_valid at T+3.
REQ-035 Sub 0x05-0x05: result=0x00, zero=1, carry=1. Eq 0x05,0x05: size=1.
REQ-036 Lt 0xF0(-16) vs 0x10: size=1. Lt 0x10 vs 0xF0: size=0.
REQ-037 Xor 0xA5,0x0F: result=0xAA, carry=0, overflow=0. Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0.
REQ-038 Assert rst during HI of add 0xFF+0x01: next cycle IDLE and out_valid=0; a following add 0x01+0x01 returns 0x02.
REQ-039 With ALU8_SEQ_OVLP_EN, stream 4 back-to-back adds with out_ready=1: results every 3 cycles. Without it: every 4 cycles.
